// File: rtl/life_pkg.sv
// Shared types and rule constants for the Game-of-Life generation sequencer.
package life_pkg;

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        SWAP
    } state_t;

    // B3/S23
    localparam logic [3:0] BIRTH_CNT  = 4'd3;
    localparam logic [3:0] SURVIVE_LO = 4'd2;
    localparam logic [3:0] SURVIVE_HI = 4'd3;

    // one wrap row above and one below the frame
    localparam int READ_EXTRA = 2;

    function automatic int read_count(input int y_size);
        return y_size + READ_EXTRA;
    endfunction

    function automatic logic cell_next(input logic alive,
                                       input logic [3:0] cnt);
        return (cnt == BIRTH_CNT) ||
               (alive && cnt >= SURVIVE_LO && cnt <= SURVIVE_HI);
    endfunction

endpackage

// File: rtl/life_generation_sequencer_row_next.sv
// Combinational next-state row from a 3-row window, all cells in parallel.
// LIFE_DEAD_BORDER_EN: cells beyond the row ends are dead instead of wrapping.
module life_row_next
    import life_pkg::*;
#(
    parameter int X_SIZE = 1280
) (
    input  logic [X_SIZE-1:0] prev_row,
    input  logic [X_SIZE-1:0] cur_row,
    input  logic [X_SIZE-1:0] next_row,
    output logic [X_SIZE-1:0] next_state
);

    logic [X_SIZE+1:0] p_ext;
    logic [X_SIZE+1:0] c_ext;
    logic [X_SIZE+1:0] n_ext;
    logic [3:0]        cnt;

`ifdef LIFE_DEAD_BORDER_EN
    assign p_ext = {1'b0, prev_row, 1'b0};
    assign c_ext = {1'b0, cur_row, 1'b0};
    assign n_ext = {1'b0, next_row, 1'b0};
`else
    assign p_ext = {prev_row[0], prev_row, prev_row[X_SIZE-1]};
    assign c_ext = {cur_row[0], cur_row, cur_row[X_SIZE-1]};
    assign n_ext = {next_row[0], next_row, next_row[X_SIZE-1]};
`endif

    // cell i sits at ext index i+1; its neighbours are at i and i+2
    always_comb begin
        next_state = '0;
        cnt        = '0;
        for (int i = 0; i < X_SIZE; i++) begin
            cnt = {3'b000, p_ext[i]}   + {3'b000, p_ext[i+1]} +
                  {3'b000, p_ext[i+2]} + {3'b000, c_ext[i]}   +
                  {3'b000, c_ext[i+2]} + {3'b000, n_ext[i]}   +
                  {3'b000, n_ext[i+1]} + {3'b000, n_ext[i+2]};
            next_state[i] = cell_next(cur_row[i], cnt);
        end
    end

endmodule

// File: rtl/life_generation_sequencer.sv
// Ping-pong Game-of-Life generation sequencer: row reads, window, row writes.
// LIFE_DEAD_BORDER_EN: treat everything outside the grid as dead cells.
module life_generation_sequencer
    import life_pkg::*;
#(
    parameter int X_SIZE     = 1280,
    parameter int Y_SIZE     = 720,
    parameter int Y_WIDTH    = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start_tick,
    input  logic               pause,
    output logic               mode,
    output logic [Y_WIDTH-1:0] line_buffer_fetch_addr,
    input  logic [X_SIZE-1:0]  line_buffer_fetch_mem,
    output logic [Y_WIDTH-1:0] parallel_next_state_write_addr,
    output logic [X_SIZE-1:0]  parallel_next_state_result,
    output logic               parallel_next_state_write_en,
    output logic               busy,
    output logic               gen_done,
    output logic [15:0]        generation_count
);

    localparam int RD_TOTAL = read_count(Y_SIZE);
    localparam int KW       = Y_WIDTH + 1;

    localparam logic [KW-1:0]      K_LAST   = KW'(RD_TOTAL - 1);
    localparam logic [KW-1:0]      K_FIRST  = KW'(READ_EXTRA);
    localparam logic [Y_WIDTH-1:0] ROW_LAST = Y_WIDTH'(Y_SIZE - 1);

    state_t state;
    state_t state_nxt;

    logic [KW-1:0]         rd_k;
    logic [RD_LATENCY-1:0] iss_pipe;
    logic [KW-1:0]         k_pipe [RD_LATENCY];

    logic              arrive;
    logic [KW-1:0]     arrive_k;
    logic [KW-1:0]     k_minus2;
    logic              pipe_busy;
    logic [X_SIZE-1:0] word_in;
    logic [X_SIZE-1:0] win_top;
    logic [X_SIZE-1:0] win_mid;
    logic [X_SIZE-1:0] row_result;

    assign arrive    = iss_pipe[RD_LATENCY-1];
    assign arrive_k  = k_pipe[RD_LATENCY-1];
    assign k_minus2  = arrive_k - K_FIRST;
    assign pipe_busy = |iss_pipe;
    assign busy      = (state != IDLE);

    // ---------------- control FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (start_tick && !pause) begin
                    state_nxt = READ;
                end
            end
            READ: begin
                if (rd_k == K_LAST) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (!pipe_busy && !parallel_next_state_write_en) begin
                    state_nxt = SWAP;
                end
            end
            SWAP: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // ---------------- read sequencing ----------------
    // Read k fetches row (k-1) mod Y_SIZE: Y-1, 0, 1, ..., Y-1, 0
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_k                   <= '0;
            line_buffer_fetch_addr <= '0;
        end else if (state == IDLE && state_nxt == READ) begin
            rd_k                   <= '0;
            line_buffer_fetch_addr <= ROW_LAST;
        end else if (state == READ && rd_k != K_LAST) begin
            rd_k <= rd_k + KW'(1);
            if (line_buffer_fetch_addr == ROW_LAST) begin
                line_buffer_fetch_addr <= '0;
            end else begin
                line_buffer_fetch_addr <= line_buffer_fetch_addr
                                          + Y_WIDTH'(1);
            end
        end
    end

    // Tracks which read's data lands on the bus each cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            iss_pipe <= '0;
            for (int i = 0; i < RD_LATENCY; i++) begin
                k_pipe[i] <= '0;
            end
        end else begin
            for (int i = RD_LATENCY - 1; i > 0; i--) begin
                iss_pipe[i] <= iss_pipe[i-1];
                k_pipe[i]   <= k_pipe[i-1];
            end
            iss_pipe[0] <= (state == READ);
            k_pipe[0]   <= rd_k;
        end
    end

    // ---------------- window and next-state ----------------
`ifdef LIFE_DEAD_BORDER_EN
    assign word_in = (arrive_k == '0 || arrive_k == K_LAST)
                     ? '0 : line_buffer_fetch_mem;
`else
    assign word_in = line_buffer_fetch_mem;
`endif

    // The arriving word is the bottom window row, used before it is stored
    life_row_next #(
        .X_SIZE (X_SIZE)
    ) u_row_next (
        .prev_row   (win_top),
        .cur_row    (win_mid),
        .next_row   (word_in),
        .next_state (row_result)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            win_top                        <= '0;
            win_mid                        <= '0;
            parallel_next_state_write_en   <= 1'b0;
            parallel_next_state_write_addr <= '0;
            parallel_next_state_result     <= '0;
        end else begin
            parallel_next_state_write_en <= 1'b0;
            if (arrive) begin
                win_top <= win_mid;
                win_mid <= word_in;
                if (arrive_k >= K_FIRST) begin
                    parallel_next_state_write_en   <= 1'b1;
                    parallel_next_state_write_addr <= k_minus2[Y_WIDTH-1:0];
                    parallel_next_state_result     <= row_result;
                end
            end
        end
    end

    // ---------------- bank swap ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode             <= 1'b0;
            gen_done         <= 1'b0;
            generation_count <= '0;
        end else begin
            gen_done <= (state == SWAP);
            if (state == SWAP) begin
                mode             <= ~mode;
                generation_count <= generation_count + 16'd1;
            end
        end
    end

endmodule

// File: tb/tb_life_generation_sequencer.sv
// Self-checking bench: two-bank RAM model plus grid-level Life reference.
module tb_life_generation_sequencer;

    localparam int XS = 8;
    localparam int YS = 6;
    localparam int YW = 3;
    localparam int RL = 1;

    typedef logic [YS-1:0][XS-1:0] grid_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start_tick = 1'b0;
    logic          pause = 1'b0;
    logic          mode;
    logic [YW-1:0] fetch_addr;
    logic [XS-1:0] fetch_mem;
    logic [YW-1:0] waddr;
    logic [XS-1:0] wres;
    logic          we;
    logic          busy;
    logic          gen_done;
    logic [15:0]   gen_cnt;

    life_generation_sequencer #(
        .X_SIZE     (XS),
        .Y_SIZE     (YS),
        .Y_WIDTH    (YW),
        .RD_LATENCY (RL)
    ) dut (
        .clk                            (clk),
        .rst                            (rst),
        .start_tick                     (start_tick),
        .pause                          (pause),
        .mode                           (mode),
        .line_buffer_fetch_addr         (fetch_addr),
        .line_buffer_fetch_mem          (fetch_mem),
        .parallel_next_state_write_addr (waddr),
        .parallel_next_state_result     (wres),
        .parallel_next_state_write_en   (we),
        .busy                           (busy),
        .gen_done                       (gen_done),
        .generation_count               (gen_cnt)
    );

    always #5 clk = ~clk;

    // two-bank RAM; loads from the bench go through the same process
    grid_t bank_a = '0;
    grid_t bank_b = '0;
    logic  ld_req = 1'b0;
    logic  ld_to_a = 1'b0;
    grid_t ld_grid = '0;

    always @(posedge clk) begin
        fetch_mem <= mode ? bank_a[fetch_addr] : bank_b[fetch_addr];
        if (ld_req) begin
            if (ld_to_a) bank_a <= ld_grid;
            else         bank_b <= ld_grid;
        end else if (we) begin
            if (mode) bank_b[waddr] <= wres;
            else      bank_a[waddr] <= wres;
        end
    end

    // activity log sampled mid-cycle
    int   rd_log[$];
    int   wr_log[$];
    int   wr_at[$];
    int   bidx = 0;
    int   starts = 0;
    int   gd_cnt = 0;
    logic busy_q = 1'b0;

    always @(negedge clk) begin
        if (busy) begin
            if (!busy_q) begin
                bidx = 0;
                starts++;
            end
            rd_log.push_back(int'(fetch_addr));
        end
        if (we) begin
            wr_log.push_back(int'(waddr));
            wr_at.push_back(bidx);
        end
        if (gen_done) gd_cnt++;
        if (busy) bidx++;
        busy_q = busy;
    end

    int n_chk = 0;
    int n_pass = 0;

    task automatic check(input string tag, input logic [63:0] got,
                         input logic [63:0] exp);
        n_chk++;
        if (got !== exp)
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        else
            n_pass++;
    endtask

    // ---------------- reference model ----------------
    function automatic logic cell_at(grid_t g, int r, int c);
`ifdef LIFE_DEAD_BORDER_EN
        if (r < 0 || r >= YS || c < 0 || c >= XS) return 1'b0;
        return g[r][c];
`else
        return g[(r + YS) % YS][(c + XS) % XS];
`endif
    endfunction

    function automatic grid_t life_step(grid_t g);
        grid_t s;
        int    n;
        s = '0;
        for (int r = 0; r < YS; r++) begin
            for (int c = 0; c < XS; c++) begin
                n = 0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++)
                        if (dr != 0 || dc != 0)
                            n += int'(cell_at(g, r + dr, c + dc));
                s[r][c] = (n == 3) || (g[r][c] && n == 2);
            end
        end
        return s;
    endfunction

    logic        exp_mode = 1'b0;
    logic [15:0] exp_count = '0;

    task automatic load_bank(input logic to_a, input grid_t g);
        @(negedge clk);
        ld_to_a = to_a;
        ld_grid = g;
        ld_req  = 1'b1;
        @(negedge clk);
        ld_req  = 1'b0;
    endtask

    task automatic clear_logs();
        rd_log.delete();
        wr_log.delete();
        wr_at.delete();
        starts = 0;
        gd_cnt = 0;
    endtask

    // one generation; tick2 > 0 re-pulses start_tick that many cycles later
    task automatic run_gen(input string nm, input grid_t seed,
                           input int tick2, input bit pause_mid,
                           output grid_t result);
        grid_t       exp_g;
        bit          seen;
        bit          order_ok;
        logic [31:0] got_r;
        logic [31:0] exp_r;
        int          first_we;
        load_bank(exp_mode, seed);
        exp_g = life_step(seed);
        clear_logs();
        @(negedge clk);
        start_tick = 1'b1;
        seen = 1'b0;
        for (int c = 1; c <= 300 && !seen; c++) begin
            @(negedge clk);
            start_tick = (tick2 > 0 && c == tick2);
            if (pause_mid && c == 4) pause = 1'b1;
            if (gen_done) seen = 1'b1;
        end
        start_tick = 1'b0;
        check({nm, "_done_seen"}, 64'(seen), 64'd1);
        repeat (3) @(negedge clk);
        pause = 1'b0;
        exp_count = exp_count + 16'd1;
        exp_mode  = ~exp_mode;
        result = exp_mode ? bank_a : bank_b;
        check({nm, "_bank"}, 64'(result), 64'(exp_g));
        check({nm, "_mode"}, 64'(mode), 64'(exp_mode));
        check({nm, "_count"}, 64'(gen_cnt), 64'(exp_count));
        check({nm, "_pulses_starts"}, {32'(gd_cnt), 32'(starts)},
              {32'd1, 32'd1});
        check({nm, "_busy_after"}, 64'(busy), 64'd0);
        got_r = '1;
        exp_r = '0;
        for (int k = 0; k < YS + 2; k++) begin
            exp_r[k*4 +: 4] = 4'((k + YS - 1) % YS);
            if (k < rd_log.size()) got_r[k*4 +: 4] = 4'(rd_log[k]);
        end
        check({nm, "_read_seq"}, 64'(got_r), 64'(exp_r));
        order_ok = (wr_log.size() == YS);
        for (int i = 0; i < wr_log.size(); i++)
            if (wr_log[i] != i || wr_at[i] != wr_at[0] + i) order_ok = 1'b0;
        check({nm, "_write_order"}, {32'(wr_log.size()), 32'(order_ok)},
              {32'(YS), 32'd1});
        first_we = (wr_at.size() > 0) ? wr_at[0] : -1;
        check({nm, "_first_we_cycle"}, 64'(first_we), 64'(2 + RL + 1));
    endtask

    grid_t g;
    grid_t r;
    grid_t e;
    logic [63:0] rnd;
    bit stayed;
    bit hit;

    initial begin
        // 1: reset
        repeat (3) @(negedge clk);
        check("reset_outputs",
              64'({mode, busy, gen_done, we, gen_cnt, waddr, wres, fetch_addr}),
              64'd0);
        rst = 1'b0;
        stayed = 1'b1;
        repeat (6) begin
            @(negedge clk);
            if (fetch_addr != '0 || busy || we) stayed = 1'b0;
        end
        check("reset_idle_quiet", 64'(stayed), 64'd1);

        // 2: vertical blinker, rows 1-3, column 3
        g = '0;
        g[1] = 8'h08; g[2] = 8'h08; g[3] = 8'h08;
        run_gen("blinker", g, 0, 1'b0, r);
        e = '0;
        e[2] = 8'b00011100;
        check("blinker_const", 64'(bank_a), 64'(e));

        // 3: blinker across the vertical wrap, rows 5, 0, 1
        g = '0;
        g[5] = 8'h08; g[0] = 8'h08; g[1] = 8'h08;
        run_gen("wrap_blinker", g, 0, 1'b0, r);
        e = '0;
`ifndef LIFE_DEAD_BORDER_EN
        e[0] = 8'b00011100;
`endif
        check("wrap_blinker_const", 64'(bank_b), 64'(e));

        // 4: paused start is ignored
        clear_logs();
        @(negedge clk);
        pause = 1'b1;
        start_tick = 1'b1;
        @(negedge clk);
        start_tick = 1'b0;
        repeat (10) @(negedge clk);
        pause = 1'b0;
        check("pause_no_activity", {32'(rd_log.size()), 32'(starts)}, 64'd0);
        check("pause_mode_count", {47'd0, mode, gen_cnt},
              {47'd0, exp_mode, exp_count});

        // 5: second tick 3 cycles later is ignored
        rnd = {$urandom(), $urandom()};
        run_gen("double_tick", grid_t'(rnd[47:0]), 3, 1'b0, r);
        clear_logs();
        repeat (10) @(negedge clk);
        check("double_tick_no_rerun", 64'(starts), 64'd0);

        // 6: reset after the third write
        rnd = {$urandom(), $urandom()};
        load_bank(exp_mode, grid_t'(rnd[47:0]));
        clear_logs();
        @(negedge clk);
        start_tick = 1'b1;
        @(negedge clk);
        start_tick = 1'b0;
        hit = 1'b0;
        for (int c = 0; c < 100 && !hit; c++) begin
            @(negedge clk);
            #1;
            if (wr_log.size() >= 3) hit = 1'b1;
        end
        check("midreset_reached_w3", 64'(hit), 64'd1);
        rst = 1'b1;
        #1;
        check("midreset_outputs",
              64'({mode, busy, gen_done, we, gen_cnt, waddr, wres, fetch_addr}),
              64'd0);
        @(negedge clk);
        rst = 1'b0;
        exp_mode  = 1'b0;
        exp_count = '0;
        rnd = {$urandom(), $urandom()};
        run_gen("after_reset", grid_t'(rnd[47:0]), 0, 1'b0, r);

        // random generations, some with pause raised mid-run
        for (int i = 0; i < 6; i++) begin
            rnd = {$urandom(), $urandom()};
            run_gen($sformatf("rand%0d", i), grid_t'(rnd[47:0]), 0,
                    1'($urandom_range(0, 1)), r);
        end

        // chained: feed each result back as the next seed
        g = r;
        for (int i = 0; i < 3; i++) begin
            run_gen($sformatf("chain%0d", i), g, 0, 1'b0, r);
            g = r;
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/life_generation_sequencer.md
Name: life_generation_sequencer

Overview:
- Drives the line-buffer side of the ping-pong Game-of-Life BRAM selector.
- Once per requested generation, it reads every row from the current-state bank and keeps a 3-row sliding window.
- It computes each next-state row with all cells in parallel, writes the rows to the other bank, then toggles `mode` so the two banks swap roles.
- It is the read-requester and next-state writer for the bank selector, and owns the `mode` signal.

Parameters:
- `X_SIZE`, 1280, cells per row (row word width).
- `Y_SIZE`, 720, rows per frame; must be ≥ 3.
- `Y_WIDTH`, 10, row address width; 2^`Y_WIDTH` ≥ `Y_SIZE`.
- `RD_LATENCY`, 1, cycles from `line_buffer_fetch_addr` to valid `line_buffer_fetch_mem`; range 1–3.

Ports:
- `clk`  in  1  system clock.
- `rst`  in  1  asynchronous reset, active-high.
- `start_tick`  in  1  one-cycle request for one generation, e.g. at vblank.
- `pause`  in  1  when high, `start_tick` is ignored.
- `mode`  out  1  bank select; 1 = read A/write B, 0 = read B/write A.
- `line_buffer_fetch_addr`  out  `Y_WIDTH`  row read address.
- `line_buffer_fetch_mem`  in  `X_SIZE`  row read data.
- `parallel_next_state_write_addr`  out  `Y_WIDTH`  row write address.
- `parallel_next_state_result`  out  `X_SIZE`  next-state row.
- `parallel_next_state_write_en`  out  1  write strobe.
- `busy`  out  1  generation in progress.
- `gen_done`  out  1  one-cycle pulse after the swap.
- `generation_count`  out  16  completed generations, wraps at 2^16.

Behaviour:
- Reset values: all outputs are 0, and the FSM is in IDLE. Reset mid-generation aborts immediately; partially written bank contents are undefined.
- FSM states:
  - IDLE: on `start_tick` with `pause`=0, go to READ and set `busy`=1. Otherwise stay.
  - READ: issue one read per cycle, `Y_SIZE`+2 reads in total. Read k (k = 0..`Y_SIZE`+1) fetches row (k−1) mod `Y_SIZE`. The sequence is therefore `Y_SIZE`−1, 0, 1, …, `Y_SIZE`−1, 0. After the last read, go to DRAIN.
  - DRAIN: wait until all writes have completed, then go to SWAP.
  - SWAP: for one cycle, toggle `mode`, pulse `gen_done`, increment `generation_count`, clear `busy`, and return to IDLE.
- Data path:
  - Word k arrives `RD_LATENCY` cycles after its read is issued and is shifted into the window (prev ← cur ← next ← word).
  - For k ≥ 2, the window holds rows k−3, k−2 and k−1; compute the next state of centre row k−2.
  - The result is registered. `parallel_next_state_write_en`=1 exactly `RD_LATENCY`+1 cycles after read k is issued, with write address k−2.
  - Writes are exactly `Y_SIZE` single-cycle strobes, in address order 0..`Y_SIZE`−1, back-to-back.
- Rule: B3/S23. Each cell's live-neighbour count is a 4-bit value over its 8 neighbours.
  - Horizontal neighbours wrap: bit 0 is adjacent to bit `X_SIZE`−1.
  - Vertical neighbours wrap through the read order.
- When `write_en`=0, the write address and result hold their last values. A selector that ignores `write_en` therefore rewrites identical data harmlessly.
- `mode` is stable from IDLE exit through the last write. It changes only in SWAP.
- `start_tick` while `busy`=1 is ignored; requests are not queued.
- `pause` rising mid-generation does not stop it: the generation completes and swaps.
- `start_tick` and SWAP in the same cycle: the tick is ignored.

Optional Feature:
- Macro: `LIFE_DEAD_BORDER_EN`.
- Defined: cells outside the grid are dead.
  - Read count and timing are unchanged.
  - Reads 0 and `Y_SIZE`+1 are still issued, but the window loads all-zero instead of the data.
  - Horizontal neighbours beyond bit 0 and bit `X_SIZE`−1 count as 0.
- Undefined: toroidal wrap on both axes, as specified above.

Decomposition:
- Package `life_pkg` holds:
  - the FSM state enum (IDLE, READ, DRAIN, SWAP);
  - the B3/S23 birth/survive count constants;
  - the read-count constant `Y_SIZE`+2.
- Sub-module `life_row_next` (combinational): inputs prev/cur/next rows; output the next-state row.
  - Internally this is a per-cell neighbour-count adder.
  - The horizontal wrap/dead-border choice is selected by the macro.

Test Plan:
All scenarios use `X_SIZE`=8, `Y_SIZE`=6, `RD_LATENCY`=1, with a two-bank behavioural RAM model behind the selector.

1. Reset: assert `rst` with no start → all outputs 0, no read addresses change, `mode`=0.
2. Vertical blinker at column 3, rows 1–3, one start → bank A row 2 = 8'b00011100 and all other rows 0.
   - Exactly 8 reads (5,0,1,2,3,4,5,0) and 6 writes (addresses 0..5).
   - `mode` 0→1, one `gen_done` pulse, `generation_count`=1.
3. Vertical blinker at column 3, rows 5, 0, 1:
   - Macro undefined → row 0 = 8'b00011100, others 0.
   - `LIFE_DEAD_BORDER_EN` defined → all rows 0.
4. `pause`=1 plus `start_tick` → no reads, `busy` stays 0, `mode` unchanged, `generation_count` unchanged.
5. Second `start_tick` 3 cycles after the first → ignored; a single generation runs, and the first write `write_en` rises 2 cycles after read k=2 is issued.
6. `rst` pulsed after the third write → all outputs 0 in the same cycle, `mode`=0. A following start completes a normal generation with `generation_count`=1.
